// File: rtl/serial_adder_mux_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
//   state_e : FSM state encoding (ST_IDLE, ST_RUN)
//   cnt_w   : bit-counter width for a given operand width
//   mux4    : 4:1 bit multiplexer used to build the full-adder cell
package serial_adder_mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter must index bits 0..width-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    function automatic logic mux4(input logic [3:0] d, input logic [1:0] sel);
        return d[sel];
    endfunction

endpackage

// File: rtl/serial_adder_mux_if.sv
// Request/result bundle for serial_adder_mux.
//   master : drives start, sub, a, b, cin; observes busy, done, sum, cout, ovf
//   slave  : the adder side of the same signals
interface serial_adder_mux_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_mux_fa_mux_cell.sv
// fa_mux_cell: 1-bit combinational full adder built from two 4:1 muxes.
// Both muxes select on {a_i, b_i}; the data inputs are functions of cin_i only.
//   a_i, b_i, cin_i : addend bits and carry in
//   s_o, c_o        : sum bit and carry out
module fa_mux_cell
    import serial_adder_mux_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic c_o
);

    logic [1:0] sel;
    logic [3:0] s_tbl;
    logic [3:0] c_tbl;

    assign sel = {a_i, b_i};

    // Index order 3..0 = {ab=11, 10, 01, 00}.
    assign s_tbl = {cin_i, ~cin_i, ~cin_i, cin_i};
    assign c_tbl = {1'b1, cin_i, cin_i, 1'b0};

    assign s_o = mux4(s_tbl, sel);
    assign c_o = mux4(c_tbl, sel);

endmodule

// File: rtl/serial_adder_mux.sv
// serial_adder_mux: bit-serial adder/subtractor, one result bit per clock, LSB first.
// An accepted request loads the operand shift registers; WIDTH clocks later sum/cout/ovf
// update together and done pulses for one cycle. Subtract is A + ~B + 1.
//   clk, rst : clock and synchronous active-high reset
//   bus      : request (start, sub, a, b, cin) and result (busy, done, sum, cout, ovf)
module serial_adder_mux
    import serial_adder_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_mux_if.slave  bus
);

    localparam int unsigned       CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    // Holds the WIDTH-1 low result bits; the MSB comes straight from the cell.
    logic [WIDTH-2:0]   res_sr_q, res_sr_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic               fa_s;
    logic               fa_c;

    fa_mux_cell u_fa (
        .a_i   (a_sr_q[0]),
        .b_i   (b_sr_q[0]),
        .cin_i (carry_q),
        .s_o   (fa_s),
        .c_o   (fa_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The done cycle is spent in ST_IDLE, so back-to-back starts land here too.
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d  = bus.sub ? 1'b1 : bus.cin;
                    res_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = (WIDTH-1)'({fa_s, res_sr_q} >> 1);
                carry_d  = fa_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // While the MSB is processed, carry_q is exactly the carry into the MSB.
                    sum_d   = {fa_s, res_sr_q};
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_mux.sv
// Bench for serial_adder_mux: a WIDTH=8 instance for directed and control corner cases
// and a WIDTH=4 instance for the exhaustive sweep. Expected results are queued at issue
// time and popped when done is observed.
module tb_serial_adder_mux;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_mux_if #(.WIDTH(8)) bus8 ();
    serial_adder_mux_if #(.WIDTH(4)) bus4 ();

    serial_adder_mux #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_adder_mux #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    // Scoreboards: {ovf, cout, sum} and accept cycle.
    logic [9:0] exp8_q[$];
    int         acc8_q[$];
    logic [5:0] exp4_q[$];

    // Reference: effective B operand, wide add, signed overflow from operand/result signs.
    function automatic logic [65:0] model(input int unsigned w, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin,
                                          input logic sub);
        logic [63:0] mask, aa, bb, s;
        logic [64:0] full;
        logic        co, ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa   = a & mask;
        bb   = sub ? (~b & mask) : (b & mask);
        full = {1'b0, aa} + {1'b0, bb} + (sub ? 65'd1 : {64'd0, cin});
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start on the 8-bit instance; returns just after the accept edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub);
        logic [65:0] m;
        m = model(8, {56'd0, a}, {56'd0, b}, cin, sub);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
        exp8_q.push_back({m[65], m[64], m[7:0]});
        tick();
        bus8.start = 1'b0;
        acc8_q.push_back(cyc);
    endtask

    task automatic wait_done8(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus8.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b1; bus8.sub = 1'b0;
        bus4.start = 1'b1; bus4.a = 4'hF;  bus4.b = 4'h1;  bus4.cin = 1'b1; bus4.sub = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus8.busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", bus8.busy);
        else n_pass++;
        n_checks++;
        if (bus8.done !== 1'b0) $display("FAIL reset done: got %b expected 0", bus8.done);
        else n_pass++;
        n_checks++;
        if (bus8.sum !== 8'h00) $display("FAIL reset sum: got %h expected 00", bus8.sum);
        else n_pass++;
        n_checks++;
        if ({bus8.cout, bus8.ovf} !== 2'b00)
            $display("FAIL reset cout/ovf: got %b%b expected 00", bus8.cout, bus8.ovf);
        else n_pass++;
        n_checks++;
        if ({bus4.busy, bus4.done, bus4.ovf, bus4.cout, bus4.sum} !== 8'h00)
            $display("FAIL reset w4 outputs: got %h expected 00",
                     {bus4.busy, bus4.done, bus4.ovf, bus4.cout, bus4.sum});
        else n_pass++;
        rst = 1'b0;
        bus8.start = 1'b0;
        bus4.start = 1'b0;
        tick();
        n_checks++;
        if (bus8.busy !== 1'b0)
            $display("FAIL start during reset latched: busy got %b expected 0", bus8.busy);
        else n_pass++;
    endtask

    task automatic test_add();
        logic [7:0] va[3] = '{8'hFF, 8'h7F, 8'h05};
        logic [7:0] vb[3] = '{8'h01, 8'h01, 8'h07};
        logic       vc[3] = '{1'b0, 1'b0, 1'b1};
        logic       vs[3] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] e;
        int         acc;
        bit         ok;
        for (int i = 0; i < 3; i++) begin
            issue8(va[i], vb[i], vc[i], vs[i]);
            wait_done8(12, ok);
            e   = exp8_q.pop_front();
            acc = acc8_q.pop_front();
            n_checks++;
            if (!ok || (cyc - acc) != 8)
                $display("FAIL op%0d latency: got %0d expected 8 (done seen %b)", i,
                         cyc - acc, ok);
            else n_pass++;
            n_checks++;
            if (bus8.sum !== e[7:0])
                $display("FAIL op%0d sum: got %h expected %h", i, bus8.sum, e[7:0]);
            else n_pass++;
            n_checks++;
            if (bus8.cout !== e[8])
                $display("FAIL op%0d cout: got %b expected %b", i, bus8.cout, e[8]);
            else n_pass++;
            n_checks++;
            if (bus8.ovf !== e[9])
                $display("FAIL op%0d ovf: got %b expected %b", i, bus8.ovf, e[9]);
            else n_pass++;
            tick();
            n_checks++;
            if (bus8.done !== 1'b0 || bus8.sum !== e[7:0])
                $display("FAIL op%0d post-done: done %b sum %h, expected done 0 sum %h", i,
                         bus8.done, bus8.sum, e[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        logic [9:0] e;
        int         acc;
        int         extra;
        bit         ok;
        issue8(8'h3C, 8'h0A, 1'b1, 1'b0);
        repeat (3) tick();
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.sub = 1'b1; bus8.cin = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        wait_done8(12, ok);
        e   = exp8_q.pop_front();
        acc = acc8_q.pop_front();
        n_checks++;
        if (!ok || (cyc - acc) != 8)
            $display("FAIL busy-start latency: got %0d expected 8 (done seen %b)",
                     cyc - acc, ok);
        else n_pass++;
        n_checks++;
        if ({bus8.ovf, bus8.cout, bus8.sum} !== e)
            $display("FAIL busy-start result: got %h expected %h",
                     {bus8.ovf, bus8.cout, bus8.sum}, e);
        else n_pass++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done || bus8.busy) extra++;
        end
        n_checks++;
        if (extra != 0)
            $display("FAIL busy-start ghost op: got %0d active cycles expected 0", extra);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [65:0] m;
        logic [9:0]  e;
        int          acc;
        bit          ok;
        issue8(8'h80, 8'h01, 1'b0, 1'b1);
        repeat (7) tick();
        // Raised one cycle early: ignored in RUN, still high during the done cycle.
        m = model(8, 64'h12, 64'h34, 1'b1, 1'b0);
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b1; bus8.sub = 1'b0; bus8.start = 1'b1;
        exp8_q.push_back({m[65], m[64], m[7:0]});
        tick();
        e   = exp8_q.pop_front();
        acc = acc8_q.pop_front();
        n_checks++;
        if (bus8.done !== 1'b1 || (cyc - acc) != 8)
            $display("FAIL b2b first done: got done %b at %0d expected 1 at 8", bus8.done,
                     cyc - acc);
        else n_pass++;
        n_checks++;
        if ({bus8.ovf, bus8.cout, bus8.sum} !== e)
            $display("FAIL b2b first result: got %h expected %h",
                     {bus8.ovf, bus8.cout, bus8.sum}, e);
        else n_pass++;
        tick();
        bus8.start = 1'b0;
        acc8_q.push_back(cyc);
        wait_done8(12, ok);
        e   = exp8_q.pop_front();
        acc = acc8_q.pop_front();
        n_checks++;
        if (!ok || (cyc - acc) != 8)
            $display("FAIL b2b second latency: got %0d expected 8 (done seen %b)",
                     cyc - acc, ok);
        else n_pass++;
        n_checks++;
        if ({bus8.ovf, bus8.cout, bus8.sum} !== e)
            $display("FAIL b2b second result: got %h expected %h",
                     {bus8.ovf, bus8.cout, bus8.sum}, e);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        issue8(8'h0F, 8'h01, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp8_q.delete();
        acc8_q.delete();
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.ovf, bus8.cout, bus8.sum} !== 12'h000)
            $display("FAIL mid-run reset outputs: got %h expected 000",
                     {bus8.busy, bus8.done, bus8.ovf, bus8.cout, bus8.sum});
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done || bus8.busy || bus8.sum != 8'h00) pulses++;
        end
        n_checks++;
        if (pulses != 0)
            $display("FAIL mid-run reset activity: got %0d cycles expected 0", pulses);
        else n_pass++;
    endtask

    task automatic test_exhaustive4();
        logic [65:0] m;
        logic [5:0]  e;
        logic [3:0]  held;
        int          acc;
        bit          ok;
        bit          stable;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int k = 0; k < 4; k++) begin
                    m = model(4, 64'(a), 64'(b), k[0], k[1]);
                    exp4_q.push_back({m[65], m[64], m[3:0]});
                    held = bus4.sum;
                    bus4.a = 4'(a); bus4.b = 4'(b);
                    bus4.cin = k[0]; bus4.sub = k[1]; bus4.start = 1'b1;
                    tick();
                    bus4.start = 1'b0;
                    acc = cyc;
                    ok = 1'b0;
                    stable = 1'b1;
                    for (int i = 0; i < 10; i++) begin
                        tick();
                        if (bus4.done) begin
                            ok = 1'b1;
                            break;
                        end
                        if (bus4.sum !== held) stable = 1'b0;
                    end
                    e = exp4_q.pop_front();
                    n_checks++;
                    if (!ok || (cyc - acc) != 4)
                        $display("FAIL w4 a=%h b=%h cin=%b sub=%b latency: got %0d expected 4",
                                 a, b, k[0], k[1], cyc - acc);
                    else n_pass++;
                    n_checks++;
                    if ({bus4.ovf, bus4.cout, bus4.sum} !== e)
                        $display("FAIL w4 a=%h b=%h cin=%b sub=%b result: got %h expected %h",
                                 a, b, k[0], k[1], {bus4.ovf, bus4.cout, bus4.sum}, e);
                    else n_pass++;
                    n_checks++;
                    if (!stable)
                        $display("FAIL w4 a=%h b=%h sum stability: got unstable expected %h",
                                 a, b, held);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        rst = 1'b1;
        test_reset();
        test_add();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
